// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h1c00_0000;
  localparam logic [31:0] INST_BYTES       = 32'd4;

endpackage

// File: rtl/fetch_perf_cnt.sv
// rtl/fetch_perf_cnt.sv - saturating fetch/drop/stall event counters
module fetch_perf_cnt
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        fetch_inc,
  input  logic        drop_inc,
  input  logic        stall_inc,
  output logic [31:0] fetch_cnt,
  output logic [31:0] drop_cnt,
  output logic [31:0] stall_cnt
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fetch_cnt <= '0;
      drop_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      // counters stick at all-ones rather than wrapping
      if (fetch_inc && (fetch_cnt != '1)) fetch_cnt <= fetch_cnt + 32'd1;
      if (drop_inc  && (drop_cnt  != '1)) drop_cnt  <= drop_cnt  + 32'd1;
      if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - single-outstanding icache requester feeding IF/ID; FETCH_PERF_EN adds event counters
module if_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] inst_raddr,
  output logic        inst_addr_valid,
  input  logic        inst_addr_ready,
  input  logic [31:0] inst_rdata,
  input  logic        inst_valid,
  output logic        inst_ready,
  output logic        if_valid,
  output logic [31:0] pc_out,
  output logic [31:0] ir_out,
  output logic [31:0] npc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] drop_cnt,
  output logic [31:0] stall_cnt
`endif
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc, pc_nxt;
  logic         wait_rdy;
  logic         capture;
  logic         discard;

  // a redirect must be able to retire a pending response even under stall
  assign wait_rdy   = redirect_valid || !(if_valid && stall);
  assign inst_raddr = pc;
  assign npc        = pc + INST_BYTES;

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    inst_addr_valid = 1'b0;
    inst_ready      = 1'b0;
    capture         = 1'b0;
    discard         = 1'b0;
    case (state)
      BOOT: state_nxt = REQ;
      REQ: begin
        inst_addr_valid = 1'b1;
        if (inst_addr_ready) state_nxt = redirect_valid ? DROP : WAIT;
      end
      WAIT: begin
        inst_ready = wait_rdy;
        if (inst_valid && wait_rdy) begin
          state_nxt = REQ;
          if (redirect_valid) begin
            discard = 1'b1;
          end else begin
            capture = 1'b1;
            pc_nxt  = pc + INST_BYTES;
          end
        end else if (redirect_valid) begin
          state_nxt = DROP;
        end
      end
      DROP: begin
        inst_ready = 1'b1;
        if (inst_valid) begin
          state_nxt = REQ;
          discard   = 1'b1;
        end
      end
      default: state_nxt = BOOT;
    endcase
    if (redirect_valid) pc_nxt = redirect_pc;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= BOOT;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      if_valid <= 1'b0;
      pc_out   <= '0;
      ir_out   <= '0;
    end else if (redirect_valid) begin
      if_valid <= 1'b0;
    end else if (capture) begin
      if_valid <= 1'b1;
      pc_out   <= pc;
      ir_out   <= inst_rdata;
    end else if (!stall) begin
      if_valid <= 1'b0;
    end
  end

`ifdef FETCH_PERF_EN
  fetch_perf_cnt u_perf (
    .clk       (clk),
    .rstn      (rstn),
    .fetch_inc (capture),
    .drop_inc  (discard),
    .stall_inc (if_valid && stall),
    .fetch_cnt (fetch_cnt),
    .drop_cnt  (drop_cnt),
    .stall_cnt (stall_cnt)
  );
`else
  logic unused_discard;
  assign unused_discard = discard;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - scoreboard bench for if_fetch_unit with a behavioural icache
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h1c00_0000;

  logic        clk = 1'b0;
  logic        rstn;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] inst_raddr;
  logic        inst_addr_valid;
  logic        inst_addr_ready;
  logic [31:0] inst_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic        if_valid;
  logic [31:0] pc_out;
  logic [31:0] ir_out;
  logic [31:0] npc;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] drop_cnt;
  logic [31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .stall           (stall),
    .inst_raddr      (inst_raddr),
    .inst_addr_valid (inst_addr_valid),
    .inst_addr_ready (inst_addr_ready),
    .inst_rdata      (inst_rdata),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .if_valid        (if_valid),
    .pc_out          (pc_out),
    .ir_out          (ir_out),
    .npc             (npc)
`ifdef FETCH_PERF_EN
    ,
    .fetch_cnt       (fetch_cnt),
    .drop_cnt        (drop_cnt),
    .stall_cnt       (stall_cnt)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] a);
    if (a == 32'h1c00_0000) return 32'h0280_0400;
    return (a ^ 32'h5a5a_0000) + 32'h0000_0013;
  endfunction

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } exp_t;
  exp_t exp_q[$];

  // reference model state
  logic [31:0] exp_pc, last_pc, last_ir, pend_addr, last_acc;
  logic        exp_ifv, exp_cap, killed, boot;
  int          acc_cnt = 0;
  int          m_fetch, m_drop, m_stall;

  // icache model state
  logic        busy;
  logic [31:0] cur_addr;
  int          cnt;
  int          lat;
  logic        c_ahs, c_rhs;
  logic [31:0] c_addr;

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  initial begin : model
    logic ahs, rhs, cap, rd;
    exp_t e;
    busy = 1'b0; inst_valid = 1'b0; inst_rdata = '0; cnt = 0; cur_addr = '0;
    c_ahs = 1'b0; c_rhs = 1'b0; c_addr = '0;
    exp_pc = RESET_PC; exp_ifv = 1'b0; exp_cap = 1'b0; killed = 1'b0; boot = 1'b1;
    last_pc = '0; last_ir = '0; pend_addr = '0; last_acc = '0;
    m_fetch = 0; m_drop = 0; m_stall = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        exp_q.delete();
        exp_pc = RESET_PC; exp_ifv = 1'b0; exp_cap = 1'b0; killed = 1'b0; boot = 1'b1;
        last_pc = '0; last_ir = '0; c_ahs = 1'b0; c_rhs = 1'b0;
        m_fetch = 0; m_drop = 0; m_stall = 0;
      end else begin
        if (exp_cap) begin
          if (exp_q.size() == 0) chk("sb_underflow", 32'd0, 32'd1);
          else begin
            e = exp_q.pop_front();
            chk("pc_out", pc_out, e.pc);
            chk("ir_out", ir_out, e.ir);
            last_pc = e.pc;
            last_ir = e.ir;
          end
        end else if (exp_ifv) begin
          chk("hold_pc", pc_out, last_pc);
          chk("hold_ir", ir_out, last_ir);
        end
        chk("if_valid", {31'd0, if_valid}, {31'd0, exp_ifv});
        chk("raddr", inst_raddr, exp_pc);
        chk("npc", npc, exp_pc + 32'd4);
        chk("addr_valid", {31'd0, inst_addr_valid}, {31'd0, !busy && !boot});
        chk("inst_ready", {31'd0, inst_ready},
            {31'd0, busy && (killed || redirect_valid || !(exp_ifv && stall))});
        rd  = redirect_valid;
        ahs = inst_addr_valid && inst_addr_ready;
        rhs = inst_valid && inst_ready;
        if (ahs) begin
          pend_addr = inst_raddr;
          killed    = rd;
          last_acc  = inst_raddr;
          acc_cnt++;
        end
        cap = rhs && !killed && !rd;
        if (cap) begin
          exp_q.push_back('{pc: pend_addr, ir: data_of(pend_addr)});
          exp_pc = pend_addr + 32'd4;
          m_fetch++;
        end
        if (rhs && !cap) m_drop++;
        if (exp_ifv && stall) m_stall++;
        exp_ifv = rd ? 1'b0 : cap ? 1'b1 : !stall ? 1'b0 : exp_ifv;
        if (rd) begin
          exp_pc = redirect_pc;
          killed = 1'b1;
        end
        exp_cap = cap;
        boot    = 1'b0;
        c_ahs   = ahs;
        c_rhs   = rhs;
        c_addr  = inst_raddr;
      end
      @(posedge clk);
      #1;
      if (!rstn) begin
        busy       = 1'b0;
        inst_valid = 1'b0;
      end else begin
        if (c_rhs) begin
          busy       = 1'b0;
          inst_valid = 1'b0;
        end
        if (c_ahs) begin
          busy     = 1'b1;
          cur_addr = c_addr;
          cnt      = lat;
        end
        if (busy && !inst_valid) begin
          if (cnt == 0) begin
            inst_valid = 1'b1;
            inst_rdata = data_of(cur_addr);
          end else cnt--;
        end
      end
    end
  end

  task automatic wait_acc(input int n, input string tag);
    int k;
    k = 0;
    while (acc_cnt <= n && k < 60) begin
      tick;
      k++;
    end
    if (acc_cnt <= n) chk(tag, 32'd0, 32'd1);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int k, n, thr;
    rstn = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; stall = 1'b0;
    inst_addr_ready = 1'b0; lat = 0;
    repeat (3) tick;
    chk("rst_addr_valid", {31'd0, inst_addr_valid}, 32'd0);
    chk("rst_inst_ready", {31'd0, inst_ready}, 32'd0);
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_pc_out", pc_out, 32'd0);
    chk("rst_ir_out", ir_out, 32'd0);
    chk("rst_raddr", inst_raddr, RESET_PC);
    rstn = 1'b1;
    inst_addr_ready = 1'b1;

    // first fetch after reset
    k = 0;
    while (!if_valid && k < 20) begin tick; k++; end
    chk("first_pc", pc_out, 32'h1c00_0000);
    chk("first_ir", ir_out, 32'h0280_0400);
    chk("first_next_raddr", inst_raddr, 32'h1c00_0004);
    repeat (10) tick;

    thr = 0;
    repeat (10) begin tick; if (if_valid) thr++; end
    chk("throughput", thr, 32'd5);

    // stall for three cycles right after a capture
    k = 0;
    while (!if_valid && k < 20) begin tick; k++; end
    chk("wait_capture", {31'd0, if_valid}, 32'd1);
    stall = 1'b1;
    repeat (3) tick;
    stall = 1'b0;
    repeat (8) tick;

    // redirect while waiting on a slow response
    lat = 2;
    repeat (4) tick;
    k = 0;
    while (!(busy && !inst_valid) && k < 40) begin tick; k++; end
    chk("wait_busy1", {31'd0, busy && !inst_valid}, 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h1c00_0100;
    n = acc_cnt;
    tick;
    redirect_valid = 1'b0;
    wait_acc(n, "timeout_redir1");
    chk("redir1_addr", last_acc, 32'h1c00_0100);
`ifdef FETCH_PERF_EN
    chk("drop_cnt_1", drop_cnt, 32'd1);
`endif
    repeat (6) tick;

    // redirect in the same cycle as the response
    lat = 1;
    repeat (4) tick;
    k = 0;
    while (!(busy && inst_valid && !killed) && k < 40) begin tick; k++; end
    chk("wait_resp2", {31'd0, busy && inst_valid}, 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h1c00_0200;
    n = acc_cnt;
    tick;
    redirect_valid = 1'b0;
    chk("redir2_if_valid", {31'd0, if_valid}, 32'd0);
    wait_acc(n, "timeout_redir2");
    chk("redir2_addr", last_acc, 32'h1c00_0200);

    // address channel back-pressure
    lat = 0;
    k = 0;
    while (busy && k < 40) begin tick; k++; end
    inst_addr_ready = 1'b0;
    repeat (5) begin
      tick;
      chk("av_held", {31'd0, inst_addr_valid}, 32'd1);
    end
    inst_addr_ready = 1'b1;
    repeat (4) tick;

    // pc wrap at the top of the address space
    redirect_valid = 1'b1; redirect_pc = 32'hffff_fffc;
    tick;
    redirect_valid = 1'b0;
    n = acc_cnt;
    wait_acc(n, "timeout_wrap1");
    chk("wrap_fetch", last_acc, 32'hffff_fffc);
    n = acc_cnt;
    wait_acc(n, "timeout_wrap2");
    chk("wrap_next", last_acc, 32'h0000_0000);
    repeat (4) tick;
`ifdef FETCH_PERF_EN
    chk("fetch_cnt", fetch_cnt, m_fetch);
    chk("drop_cnt", drop_cnt, m_drop);
    chk("stall_cnt", stall_cnt, m_stall);
`endif

    // asynchronous reset while a request is outstanding
    lat = 5;
    repeat (3) tick;
    k = 0;
    while (!(busy && !inst_valid) && k < 40) begin tick; k++; end
    chk("wait_busy3", {31'd0, busy && !inst_valid}, 32'd1);
    #1 rstn = 1'b0;
    #1;
    chk("mid_rst_addr_valid", {31'd0, inst_addr_valid}, 32'd0);
    chk("mid_rst_inst_ready", {31'd0, inst_ready}, 32'd0);
    chk("mid_rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("mid_rst_pc_out", pc_out, 32'd0);
    chk("mid_rst_ir_out", ir_out, 32'd0);
    chk("mid_rst_raddr", inst_raddr, RESET_PC);
    tick;
    tick;
    lat = 0;
    rstn = 1'b1;
    n = acc_cnt;
    wait_acc(n, "timeout_refetch");
    chk("refetch_addr", last_acc, RESET_PC);
    repeat (10) tick;

    inst_addr_ready = 1'b0;
    repeat (8) tick;
    chk("sb_drain", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
